// File: rtl/snake_pkg.sv
// Shared definitions for the snake game datapath: playfield geometry and
// the decoded move direction used by the head tracker.
package snake_pkg;

    localparam int COORD_W = 3;
    localparam int X_MAX   = 7;
    localparam int Y_MAX   = 7;

    typedef enum logic [2:0] {
        DIR_NONE,
        DIR_L,
        DIR_R,
        DIR_U,
        DIR_D
    } dir_t;

endpackage

// File: rtl/dir_priority_enc.sv
// Collapses the four raw direction requests into a single move,
// resolving simultaneous requests with the fixed order l > r > u > d.
module dir_priority_enc
    import snake_pkg::*;
(
    input  logic l,
    input  logic r,
    input  logic u,
    input  logic d,
    output dir_t dir
);

    always_comb begin
        dir = DIR_NONE;
        if (l) begin
            dir = DIR_L;
        end else if (r) begin
            dir = DIR_R;
        end else if (u) begin
            dir = DIR_U;
        end else if (d) begin
            dir = DIR_D;
        end
    end

endmodule

// File: rtl/position_recorder.sv
// Snake-head coordinate register with single-step moves, absolute load and
// a sticky edge-collision flag that freezes the head until reset or load.
module position_recorder
    import snake_pkg::*;
#(
    parameter int COORD_W = snake_pkg::COORD_W,
    parameter int X_MAX   = snake_pkg::X_MAX,
    parameter int Y_MAX   = snake_pkg::Y_MAX,
    parameter int RESET_X = 4,
    parameter int RESET_Y = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               l,
    input  logic               r,
    input  logic               u,
    input  logic               d,
    input  logic               load,
    input  logic [COORD_W-1:0] load_x,
    input  logic [COORD_W-1:0] load_y,
    output logic [COORD_W-1:0] motion_x,
    output logic [COORD_W-1:0] motion_y,
    output logic               edge_collision
);

    localparam logic [COORD_W-1:0] X_LIM  = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] Y_LIM  = COORD_W'(Y_MAX);
    localparam logic [COORD_W-1:0] X_INIT = COORD_W'(RESET_X);
    localparam logic [COORD_W-1:0] Y_INIT = COORD_W'(RESET_Y);

    dir_t               dir;
    logic [COORD_W-1:0] next_x;
    logic [COORD_W-1:0] next_y;
    logic               next_collision;
    logic [COORD_W-1:0] sat_load_x;
    logic [COORD_W-1:0] sat_load_y;

    dir_priority_enc u_dir_enc (
        .l   (l),
        .r   (r),
        .u   (u),
        .d   (d),
        .dir (dir)
    );

    assign sat_load_x = (load_x > X_LIM) ? X_LIM : load_x;
    assign sat_load_y = (load_y > Y_LIM) ? Y_LIM : load_y;

    // Bounds are tested before stepping so an illegal move never wraps.
    always_comb begin
        next_x         = motion_x;
        next_y         = motion_y;
        next_collision = edge_collision;
        if (!edge_collision) begin
            case (dir)
                DIR_L: begin
                    if (motion_x == '0) next_collision = 1'b1;
                    else                next_x = motion_x - 1'b1;
                end
                DIR_R: begin
                    if (motion_x == X_LIM) next_collision = 1'b1;
                    else                   next_x = motion_x + 1'b1;
                end
                DIR_U: begin
                    if (motion_y == '0) next_collision = 1'b1;
                    else                next_y = motion_y - 1'b1;
                end
                DIR_D: begin
                    if (motion_y == Y_LIM) next_collision = 1'b1;
                    else                   next_y = motion_y + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            motion_x       <= X_INIT;
            motion_y       <= Y_INIT;
            edge_collision <= 1'b0;
        end else if (load) begin
            motion_x       <= sat_load_x;
            motion_y       <= sat_load_y;
            edge_collision <= 1'b0;
        end else begin
            motion_x       <= next_x;
            motion_y       <= next_y;
            edge_collision <= next_collision;
        end
    end

endmodule

// File: tb/tb_position_recorder.sv
// Self-checking bench for position_recorder: a signed-integer playfield
// model checked every cycle, plus hand-computed literal checkpoints.
module tb_position_recorder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       l = 1'b0;
    logic       r = 1'b0;
    logic       u = 1'b0;
    logic       d = 1'b0;
    logic       load = 1'b0;
    logic [2:0] load_x = '0;
    logic [2:0] load_y = '0;
    logic [2:0] motion_x;
    logic [2:0] motion_y;
    logic       edge_collision;

    int checks = 0;
    int errors = 0;
    int mx = 0;
    int my = 0;
    bit mcol = 1'b0;
    bit model_valid = 1'b0;

    always #5 clk = ~clk;

    position_recorder dut (
        .clk            (clk),
        .reset          (reset),
        .l              (l),
        .r              (r),
        .u              (u),
        .d              (d),
        .load           (load),
        .load_x         (load_x),
        .load_y         (load_y),
        .motion_x       (motion_x),
        .motion_y       (motion_y),
        .edge_collision (edge_collision)
    );

    // Model tracks the head as plain integers on a 0..7 grid.
    task automatic applyStimulus(input bit i_rst, input bit i_l, input bit i_r,
                                 input bit i_u, input bit i_d, input bit i_ld,
                                 input int lx, input int ly);
        int dx;
        int dy;
        reset  = i_rst;
        l      = i_l;
        r      = i_r;
        u      = i_u;
        d      = i_d;
        load   = i_ld;
        load_x = 3'(lx);
        load_y = 3'(ly);
        @(posedge clk);
        dx = 0;
        dy = 0;
        if (i_rst) begin
            mx = 4;
            my = 4;
            mcol = 1'b0;
            model_valid = 1'b1;
        end else if (i_ld) begin
            mx = (lx > 7) ? 7 : lx;
            my = (ly > 7) ? 7 : ly;
            mcol = 1'b0;
        end else if (!mcol) begin
            if (i_l)      dx = -1;
            else if (i_r) dx = 1;
            else if (i_u) dy = -1;
            else if (i_d) dy = 1;
            if (mx + dx < 0 || mx + dx > 7 || my + dy < 0 || my + dy > 7)
                mcol = 1'b1;
            else begin
                mx = mx + dx;
                my = my + dy;
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic stepDir(input bit i_l, input bit i_r, input bit i_u,
                           input bit i_d, input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, i_l, i_r, i_u, i_d, 1'b0, 0, 0);
    endtask

    task automatic checkOutput(input string name, input int ex, input int ey,
                               input bit ec);
        checks++;
        if (motion_x !== 3'(ex) || motion_y !== 3'(ey) || edge_collision !== ec) begin
            errors++;
            $display("[TB] FAIL %s: got (%0d,%0d,col=%0b) expected (%0d,%0d,col=%0b)",
                     name, motion_x, motion_y, edge_collision, ex, ey, ec);
        end
    endtask

    always @(negedge clk) begin
        if (model_valid) begin
            checks++;
            if (motion_x !== 3'(mx) || motion_y !== 3'(my) || edge_collision !== mcol) begin
                errors++;
                $display("[TB] FAIL model t=%0t: got (%0d,%0d,col=%0b) expected (%0d,%0d,col=%0b)",
                         $time, motion_x, motion_y, edge_collision, mx, my, mcol);
            end
        end
    end

    initial begin
        applyStimulus(1'b1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset", 4, 4, 1'b0);

        stepDir(1, 0, 0, 0, 1);
        checkOutput("left1", 3, 4, 1'b0);
        stepDir(1, 0, 0, 0, 2);
        checkOutput("left3", 1, 4, 1'b0);

        applyStimulus(1'b1, 0, 0, 0, 0, 0, 0, 0);
        stepDir(0, 1, 0, 0, 3);
        checkOutput("right3", 7, 4, 1'b0);
        stepDir(0, 1, 0, 0, 1);
        checkOutput("right_edge", 7, 4, 1'b1);
        stepDir(0, 1, 0, 0, 1);
        stepDir(1, 0, 0, 0, 2);
        checkOutput("frozen", 7, 4, 1'b1);

        applyStimulus(1'b1, 0, 0, 0, 0, 0, 0, 0);
        stepDir(0, 0, 0, 1, 3);
        checkOutput("down3", 4, 7, 1'b0);
        stepDir(0, 0, 0, 1, 1);
        checkOutput("down_edge", 4, 7, 1'b1);

        applyStimulus(1'b1, 0, 0, 0, 0, 0, 0, 0);
        stepDir(0, 0, 1, 0, 4);
        checkOutput("up4", 4, 0, 1'b0);
        stepDir(0, 0, 1, 0, 1);
        checkOutput("up_edge", 4, 0, 1'b1);
        applyStimulus(1'b0, 0, 0, 0, 0, 1'b1, 3, 3);
        checkOutput("load_clears", 3, 3, 1'b0);

        applyStimulus(1'b1, 0, 0, 0, 0, 0, 0, 0);
        stepDir(1, 0, 1, 0, 1);
        checkOutput("left_wins", 3, 4, 1'b0);
        stepDir(0, 0, 0, 0, 3);
        checkOutput("idle_hold", 3, 4, 1'b0);
        stepDir(0, 1, 1, 1, 1);
        checkOutput("right_over_ud", 4, 4, 1'b0);
        stepDir(0, 0, 1, 1, 1);
        checkOutput("up_over_down", 4, 3, 1'b0);

        applyStimulus(1'b1, 0, 0, 0, 0, 1'b1, 1, 2);
        checkOutput("reset_over_load", 4, 4, 1'b0);
        applyStimulus(1'b0, 0, 1'b1, 0, 0, 1'b1, 1, 2);
        checkOutput("load_over_move", 1, 2, 1'b0);
        stepDir(1, 0, 0, 0, 1);
        checkOutput("left_to_zero", 0, 2, 1'b0);
        stepDir(1, 0, 0, 0, 1);
        checkOutput("left_edge", 0, 2, 1'b1);

        model_valid = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
